wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_initiator_pkg.sv | 18 +
 rtl/wb_initiator_if.sv | 44 ++++
 rtl/wb_initiator.sv | 140 ++++++++++++++
 tb/tb_wb_initiator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types for the Wishbone single-transaction initiator: FSM states and
// response status encodings.
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } state_e;

  typedef logic [1:0] rsp_status_t;

  localparam rsp_status_t StatusOk      = 2'b00;
  localparam rsp_status_t StatusBusErr  = 2'b01;
  localparam rsp_status_t StatusTimeout = 2'b10;

endpackage

// File: rtl/wb_initiator_if.sv
// Bundle of command, response and Wishbone signals around wb_initiator.
// The master modport is the initiator's view; the slave modport is the view of
// the command source / responder environment.
interface wb_initiator_if #(
  parameter int unsigned AW = 30
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic [3:0]    cmd_sel;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_status;

  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel;
  logic          wb_ack;
  logic          wb_stall;
  logic          wb_err;
  logic [31:0]   wb_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel, rsp_ready,
    input  wb_ack, wb_stall, wb_err, wb_dat_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_status,
    output wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_o, wb_sel
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_sel, rsp_ready,
    output wb_ack, wb_stall, wb_err, wb_dat_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status,
    input  wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_o, wb_sel
  );

endinterface

// File: rtl/wb_initiator.sv
// Wishbone pipelined single-transaction initiator. Accepts one command, runs
// one bus cycle (with stall handling and a timeout), and returns one response.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned AW      = 30,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,

  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [31:0]   i_cmd_data,
  input  logic [3:0]    i_cmd_sel,

  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [31:0]   o_rsp_data,
  output logic [1:0]    o_rsp_status,

  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  // Smallest counter that can hold TIMEOUT; it stops at TIMEOUT so never wraps.
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_data;
  logic [3:0]      r_sel;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_data;
  rsp_status_t     r_rsp_status;

  logic            w_done;
  logic            w_timeout;

  // Bus completion and timeout detection; ack/err beat a same-cycle timeout.
  always_comb begin
    w_done    = i_wb_ack || i_wb_err;
    w_timeout = !w_done && (r_cnt == TimeoutVal);
  end

  // Transaction FSM with all bus/response outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_sel        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= StatusOk;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_we    <= i_cmd_we;
            r_addr  <= i_cmd_addr;
            r_data  <= i_cmd_data;
            r_sel   <= i_cmd_sel;
            r_cnt   <= '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= StReq;
          end
        end
        StReq, StWait: begin
          if (w_done) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
            if (i_wb_err) begin
              r_rsp_status <= StatusBusErr;
              r_rsp_data   <= '0;
            end else begin
              r_rsp_status <= StatusOk;
              r_rsp_data   <= r_we ? 32'h0 : i_wb_data;
            end
          end else if (w_timeout) begin
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= StatusTimeout;
            r_rsp_data   <= '0;
            r_state      <= StResp;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            if ((r_state == StReq) && !i_wb_stall) begin
              r_stb   <= 1'b0;
              r_state <= StWait;
            end
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Ready is gated by reset so it reads low for the whole reset assertion.
  assign o_cmd_ready  = i_reset_n && (r_state == StIdle);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_status = r_rsp_status;
  assign o_wb_cyc     = r_cyc;
  assign o_wb_stb     = r_stb;
  assign o_wb_we      = r_we;
  assign o_wb_addr    = r_addr;
  assign o_wb_data    = r_data;
  assign o_wb_sel     = r_sel;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator (TIMEOUT=8).
module tb_wb_initiator;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  wb_initiator_if #(.AW(30)) bus ();

  wb_initiator #(
    .AW      (30),
    .TIMEOUT (8)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_cmd_valid  (bus.cmd_valid),
    .o_cmd_ready  (bus.cmd_ready),
    .i_cmd_we     (bus.cmd_we),
    .i_cmd_addr   (bus.cmd_addr),
    .i_cmd_data   (bus.cmd_data),
    .i_cmd_sel    (bus.cmd_sel),
    .o_rsp_valid  (bus.rsp_valid),
    .i_rsp_ready  (bus.rsp_ready),
    .o_rsp_data   (bus.rsp_data),
    .o_rsp_status (bus.rsp_status),
    .o_wb_cyc     (bus.wb_cyc),
    .o_wb_stb     (bus.wb_stb),
    .o_wb_we      (bus.wb_we),
    .o_wb_addr    (bus.wb_addr),
    .o_wb_data    (bus.wb_dat_o),
    .o_wb_sel     (bus.wb_sel),
    .i_wb_ack     (bus.wb_ack),
    .i_wb_stall   (bus.wb_stall),
    .i_wb_err     (bus.wb_err),
    .i_wb_data    (bus.wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wb_ack    = 1'b0;
    bus.wb_stall  = 1'b0;
    bus.wb_err    = 1'b0;
    bus.wb_dat_i  = '0;

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_cyc", 32'(bus.wb_cyc), 32'd0);
    check("rst_stb", 32'(bus.wb_stb), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_addr", 32'(bus.wb_addr), 32'd0);
    check("rst_status", 32'(bus.rsp_status), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Zero-stall read, ack one cycle after stb
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 30'h5;
    bus.cmd_sel   = 4'hF;
    tick();                                  // edge N: accept
    bus.cmd_valid = 1'b0;
    check("rd_cyc_n1", 32'(bus.wb_cyc), 32'd1);
    check("rd_stb_n1", 32'(bus.wb_stb), 32'd1);
    check("rd_addr_n1", 32'(bus.wb_addr), 32'h5);
    check("rd_we_n1", 32'(bus.wb_we), 32'd0);
    check("rd_ready_n1", 32'(bus.cmd_ready), 32'd0);
    tick();                                  // edge N+1: stb accepted
    check("rd_stb_n2", 32'(bus.wb_stb), 32'd0);
    check("rd_cyc_n2", 32'(bus.wb_cyc), 32'd1);
    check("rd_rspv_n2", 32'(bus.rsp_valid), 32'd0);
    bus.wb_ack   = 1'b1;
    bus.wb_dat_i = 32'h1234_5678;
    tick();                                  // edge N+2: ack sampled
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = 32'h0;
    check("rd_rspv_n3", 32'(bus.rsp_valid), 32'd1);
    check("rd_data", bus.rsp_data, 32'h1234_5678);
    check("rd_status", 32'(bus.rsp_status), 32'd0);
    check("rd_cyc_n3", 32'(bus.wb_cyc), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rd_rspv_done", 32'(bus.rsp_valid), 32'd0);
    check("rd_ready_done", 32'(bus.cmd_ready), 32'd1);

    // Write with stall held for the first 3 stb cycles
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 30'h10;
    bus.cmd_data  = 32'hDEAD_BEEF;
    bus.cmd_sel   = 4'hF;
    bus.wb_stall  = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 32'h0;
    bus.cmd_addr  = 30'h0;
    for (int i = 0; i < 4; i++) begin
      check("wr_stb_high", 32'(bus.wb_stb), 32'd1);
      check("wr_addr_hold", 32'(bus.wb_addr), 32'h10);
      check("wr_data_hold", bus.wb_dat_o, 32'hDEAD_BEEF);
      check("wr_we_hold", 32'(bus.wb_we), 32'd1);
      if (i == 3) bus.wb_stall = 1'b0;
      tick();
    end
    check("wr_stb_low", 32'(bus.wb_stb), 32'd0);
    check("wr_cyc_wait", 32'(bus.wb_cyc), 32'd1);
    check("wr_addr_wait", 32'(bus.wb_addr), 32'h10);
    check("wr_sel_wait", 32'(bus.wb_sel), 32'hF);
    bus.wb_ack   = 1'b1;
    bus.wb_dat_i = 32'hFFFF_0000;
    tick();
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = 32'h0;
    check("wr_rspv", 32'(bus.rsp_valid), 32'd1);
    check("wr_status", 32'(bus.rsp_status), 32'd0);
    check("wr_data_zero", bus.rsp_data, 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Timeout: no ack, counter runs 0..8 with cyc high, then abort
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 30'h20;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("to_cyc_high", 32'(bus.wb_cyc), 32'd1);
      tick();
    end
    check("to_cyc_low", 32'(bus.wb_cyc), 32'd0);
    check("to_rspv", 32'(bus.rsp_valid), 32'd1);
    check("to_status", 32'(bus.rsp_status), 32'd2);
    check("to_data", bus.rsp_data, 32'h0);
    bus.wb_ack   = 1'b1;
    bus.wb_dat_i = 32'hA5A5_A5A5;
    tick();                                  // stray ack in RESP
    check("to_stray_status", 32'(bus.rsp_status), 32'd2);
    check("to_stray_data", bus.rsp_data, 32'h0);
    check("to_stray_cyc", 32'(bus.wb_cyc), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();                                  // stray ack in IDLE
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = 32'h0;
    check("idle_stray_rspv", 32'(bus.rsp_valid), 32'd0);
    check("idle_stray_cyc", 32'(bus.wb_cyc), 32'd0);

    // err+ack together, then response back-pressure with a second command offered
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 30'h30;
    tick();
    bus.cmd_addr  = 30'h7;                   // second command, held valid
    bus.wb_ack    = 1'b1;
    bus.wb_err    = 1'b1;
    bus.wb_dat_i  = 32'h5555_AAAA;
    tick();
    bus.wb_ack    = 1'b0;
    bus.wb_err    = 1'b0;
    bus.wb_dat_i  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rspv", 32'(bus.rsp_valid), 32'd1);
      check("bp_status", 32'(bus.rsp_status), 32'd1);
      check("bp_data", bus.rsp_data, 32'h0);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_cyc", 32'(bus.wb_cyc), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("handoff_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    bus.rsp_ready = 1'b0;
    check("handoff_rspv", 32'(bus.rsp_valid), 32'd0);
    check("handoff_cyc", 32'(bus.wb_cyc), 32'd0);
    check("handoff_idle_ready", 32'(bus.cmd_ready), 32'd1);
    tick();                                  // second command accepted here
    bus.cmd_valid = 1'b0;
    check("cmd2_cyc", 32'(bus.wb_cyc), 32'd1);
    check("cmd2_addr", 32'(bus.wb_addr), 32'h7);
    bus.wb_ack   = 1'b1;                     // ack while still in REQ
    bus.wb_dat_i = 32'hCAFE_F00D;
    tick();
    bus.wb_ack   = 1'b0;
    bus.wb_dat_i = 32'h0;
    check("cmd2_rspv", 32'(bus.rsp_valid), 32'd1);
    check("cmd2_data", bus.rsp_data, 32'hCAFE_F00D);
    check("cmd2_status", 32'(bus.rsp_status), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset during WAIT
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 30'h44;
    tick();
    bus.cmd_valid = 1'b0;
    tick();                                  // now in WAIT
    check("wr_wait_cyc", 32'(bus.wb_cyc), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_cyc", 32'(bus.wb_cyc), 32'd0);
    check("mid_rst_stb", 32'(bus.wb_stb), 32'd0);
    check("mid_rst_rspv", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("mid_rst_addr", 32'(bus.wb_addr), 32'h0);
    reset_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(bus.cmd_ready), 32'd1);
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    check("mid_rel_rspv", 32'(bus.rsp_valid), 32'd0);
    check("mid_rel_cyc", 32'(bus.wb_cyc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
